// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Next priority position after v, wrapping at n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v >= n - 1) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search: first set request at or after ptr, wrapping.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N_REQ = 16,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N_REQ);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W:0]     off;
    logic [IDX_W:0]     sum;

    // Rotating the doubled vector puts position ptr at bit 0, so a plain
    // lowest-set-bit encode gives the distance from ptr to the winner.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N_REQ-1:0];
        found = |req;
        off   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = (IDX_W + 1)'(i);
        end
        sum = {1'b0, ptr} + off;
        if (sum >= N_EXT) sum = sum - N_EXT;
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with registered one-hot and binary grant, plus optional hold timeout.
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 16,
    parameter int IDX_W    = idx_width(N_REQ),
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             gnt_new_o,
    output arb_state_e       dbg_state
);

    // With the timeout disabled the counter just saturates at all-ones and is never consulted.
    localparam logic [HOLD_W-1:0] HOLD_LIM = (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              new_q, new_d;

    logic              found;
    logic [IDX_W-1:0]  pick_idx;
    logic              timeout;
    logic              arbitrate;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr_q),
        .found (found),
        .idx   (pick_idx)
    );

    assign timeout = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        new_d     = 1'b0;
        arbitrate = 1'b0;
        case (state_q)
            IDLE: arbitrate = 1'b1;
            GRANT: begin
                if (!req_i[idx_q] || timeout) begin
                    arbitrate = 1'b1;
                end else if (hold_q != HOLD_LIM) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: arbitrate = 1'b1;
        endcase
        // On timeout the owner still requests, but ptr already sits just past it,
        // so it only wins again when nobody else is waiting.
        if (arbitrate) begin
            if (found) begin
                state_d = GRANT;
                idx_d   = pick_idx;
                ptr_d   = IDX_W'(wrap_inc(32'(pick_idx), N_REQ));
                hold_d  = HOLD_W'(1);
                new_d   = 1'b1;
            end else begin
                state_d = IDLE;
                idx_d   = '0;
                hold_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            new_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            new_q   <= new_d;
        end
    end

    always_comb begin
        gnt_valid_o = (state_q == GRANT);
        gnt_idx_o   = idx_q;
        gnt_new_o   = new_q;
        dbg_state   = state_q;
        gnt_o       = gnt_valid_o ? (N_REQ'(1) << idx_q) : '0;
    end

endmodule
